// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the architectural PC, issues one outstanding
// imem request at a time and hands instructions to decode through a one-entry buffer.
module if_fetch_unit #(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      branch,
  input  logic [XLEN-1:0] branch_target,
  input  logic [XLEN-1:0] jump_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc_plus4,
  output logic [XLEN-1:0] if_instr,
  output logic            misalign
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_FULL = 2'd3
  } state_t;

  localparam logic [XLEN-1:0] PC_STEP   = XLEN'(32'd4);
  localparam logic [XLEN-1:0] BIT0_MASK = ~XLEN'(32'd1);

  state_t          state_r;
  logic [XLEN-1:0] pc_r;
  logic            kill_r;
  logic            req_r;
  logic            valid_r;
  logic [XLEN-1:0] if_pc_r;
  logic [XLEN-1:0] plus4_r;
  logic [XLEN-1:0] instr_r;
  logic            misalign_r;

  logic            redirect_s;
  logic [XLEN-1:0] target_s;
  logic [XLEN-1:0] pc_next_s;

  // Redirect decode: 01 selects the conditional target, 1x the jump target.
  always_comb begin
    redirect_s = 1'b0;
    target_s   = {XLEN{1'b0}};
    pc_next_s  = pc_r + PC_STEP;
    if (branch != 2'b00) begin
      redirect_s = 1'b1;
    end else begin
      redirect_s = 1'b0;
    end
    if (branch[1]) begin
      target_s = jump_target;
    end else begin
      target_s = branch_target;
    end
  end

  // Fetch FSM with registered request, buffer and misalign outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      pc_r       <= RESET_PC;
      kill_r     <= 1'b0;
      req_r      <= 1'b0;
      valid_r    <= 1'b0;
      if_pc_r    <= {XLEN{1'b0}};
      plus4_r    <= PC_STEP;
      instr_r    <= {XLEN{1'b0}};
      misalign_r <= 1'b0;
    end else if (redirect_s) begin
      // Redirect wins over any response or handshake in the same cycle.
      pc_r       <= target_s & BIT0_MASK;
      misalign_r <= target_s[1];
      case (state_r)
        S_IDLE: begin
          state_r <= S_REQ;
          req_r   <= 1'b1;
        end
        S_REQ: begin
          if (imem_ready) begin
            kill_r  <= 1'b1;
            state_r <= S_WAIT;
            req_r   <= 1'b0;
          end else begin
            state_r <= S_REQ;
            req_r   <= 1'b1;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            kill_r  <= 1'b0;
            state_r <= S_REQ;
            req_r   <= 1'b1;
          end else begin
            kill_r  <= 1'b1;
            state_r <= S_WAIT;
          end
        end
        S_FULL: begin
          valid_r <= 1'b0;
          state_r <= S_REQ;
          req_r   <= 1'b1;
        end
        default: begin
          state_r <= S_IDLE;
          kill_r  <= 1'b0;
          req_r   <= 1'b0;
          valid_r <= 1'b0;
        end
      endcase
    end else begin
      misalign_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          state_r <= S_REQ;
          req_r   <= 1'b1;
        end
        S_REQ: begin
          if (imem_ready) begin
            state_r <= S_WAIT;
            req_r   <= 1'b0;
          end else begin
            state_r <= S_REQ;
            req_r   <= 1'b1;
          end
        end
        S_WAIT: begin
          if (imem_rvalid && kill_r) begin
            // Response belongs to a fetch that a redirect already abandoned.
            kill_r  <= 1'b0;
            state_r <= S_REQ;
            req_r   <= 1'b1;
          end else if (imem_rvalid) begin
            instr_r <= imem_rdata;
            if_pc_r <= pc_r;
            plus4_r <= pc_next_s;
            pc_r    <= pc_next_s;
            valid_r <= 1'b1;
            state_r <= S_FULL;
          end else begin
            state_r <= S_WAIT;
          end
        end
        S_FULL: begin
          if (if_ready) begin
            valid_r <= 1'b0;
            state_r <= S_REQ;
            req_r   <= 1'b1;
          end else begin
            state_r <= S_FULL;
          end
        end
        default: begin
          state_r <= S_IDLE;
          kill_r  <= 1'b0;
          req_r   <= 1'b0;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = req_r;
  assign imem_addr   = pc_r;
  assign if_valid    = valid_r;
  assign if_pc       = if_pc_r;
  assign if_pc_plus4 = plus4_r;
  assign if_instr    = instr_r;
  assign misalign    = misalign_r;

endmodule
